// File: rtl/ahb2apb_req_arbiter_pkg.sv
// ahb2apb_arb_pkg: shared types and AHB-lite encodings for the requester
// arbiter in front of the AHB2APB bridge.
//   state_e        : transfer sequencer states (IDLE, ADDR, DATA)
//   HTRANS_*       : AHB-lite transfer type encodings used by the sequencer
//   HSIZE_WORD     : the only transfer size issued (32-bit word)
package ahb2apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/ahb2apb_req_arbiter_rr.sv
// rr_arbiter: round-robin arbiter over NUM_REQ request lines.
//   hclk, hreset : clock, synchronous active-high reset
//   req          : request vector
//   enable       : grant is consumed this cycle; advances the pointer
//   grant        : one-hot winner (zero when no request)
//   grant_idx    : index of the winner
// The search starts one past the last winner, so after reset (pointer at
// NUM_REQ-1) requester 0 has top priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] r_last;
  logic             w_found;
  int               w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // wrap without a modulo operator so non-power-of-two counts stay cheap
      w_j = int'(r_last) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!w_found && req[w_j]) begin
        w_found    = 1'b1;
        grant[w_j] = 1'b1;
        grant_idx  = IDX_W'(w_j);
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)                r_last <= IDX_W'(NUM_REQ - 1);
    else if (enable && |req)   r_last <= grant_idx;
  end

endmodule

// File: rtl/ahb2apb_req_arbiter.sv
// ahb2apb_req_arbiter: shares the AHB2APB bridge slave port between NUM_REQ
// register-access requesters. Each accepted request becomes one NONSEQ word
// transfer; the response (read data, error) returns to the owning requester.
//   hclk, hreset        : clock, synchronous active-high reset
//   req_valid/write/addr/wdata : per-requester request (packed slices)
//   req_ready           : combinational one-hot accept, IDLE only
//   rsp_valid           : one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err  : captured HRDATA / HRESP of the completed transfer
//   hsel..hwdata        : registered AHB-lite master outputs to the bridge
//   hready, hrdata, hresp : bridge hreadyout, read data, response
module ahb2apb_req_arbiter
  import ahb2apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          hsel,
  output logic [1:0]                    htrans,
  output logic [ADDR_WIDTH-1:0]         haddr,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [DATA_WIDTH-1:0]         hwdata,
  input  logic                          hready,
  input  logic [DATA_WIDTH-1:0]         hrdata,
  input  logic                          hresp
);

  state_e              r_state, w_next;
  logic [IDX_W-1:0]    r_owner;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_arb_en;
  logic                w_accept;
  logic                w_addr_done;
  logic                w_data_done;

  // reset also masks the accept so req_ready reads 0 while hreset is high
  assign w_arb_en    = (r_state == IDLE) && !hreset;
  assign w_accept    = w_arb_en && |req_valid;
  assign w_addr_done = (r_state == ADDR) && hready;
  assign w_data_done = (r_state == DATA) && hready;

  assign req_ready = w_arb_en ? w_grant : '0;
  assign hsize     = HSIZE_WORD;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .hclk      (hclk),
    .hreset    (hreset),
    .req       (req_valid),
    .enable    (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (|req_valid) w_next = ADDR;
      ADDR:    if (hready)     w_next = DATA;
      DATA:    if (hready)     w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_wdata   <= '0;
      hsel      <= 1'b0;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= '0;
      // address phase registers double as the holding registers for addr/write
      if (w_accept) begin
        haddr   <= req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        hwrite  <= req_write[w_grant_idx];
        r_wdata <= req_wdata[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_owner <= w_grant_idx;
        hsel    <= 1'b1;
        htrans  <= HTRANS_NONSEQ;
      end
      // hwdata is driven in the data phase even for reads; the bridge ignores it
      if (w_addr_done) begin
        hsel   <= 1'b0;
        htrans <= HTRANS_IDLE;
        hwdata <= r_wdata;
      end
      // hresp during a wait cycle is the first half of an ERROR; only the
      // completing edge is captured
      if (w_data_done) begin
        rsp_valid <= NUM_REQ'(1) << r_owner;
        rsp_rdata <= hrdata;
        rsp_err   <= hresp;
      end
    end
  end

endmodule
